buffer_wr_ctrl: RTL and testbench

Write-side controller for the dual-read-port operand buffer. Accepts a valid/ready word stream from the memory interface, turns each accepted word into a registered single-port write (`wrt`, `wrt_addr`, `data_out`), and tracks occupancy against entries released by the read side. Sits between the off-chip load path and the buffer's write port.

---
 rtl/buffer_wr_ctrl_pkg.sv | 9 +
 rtl/buffer_wr_ctrl_if.sv | 16 +
 rtl/buffer_wr_ctrl_occupancy_counter.sv | 41 ++++
 rtl/buffer_wr_ctrl.sv | 85 ++++++++
 tb/tb_buffer_wr_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/buffer_wr_ctrl_pkg.sv
// buffer_wr_ctrl_pkg: shared state encoding and default widths for the buffer write controller.
//   ADDR_LEN  default buffer address width
//   DATA_LEN  default word width
//   state_t   controller states IDLE / FILL / DONE
package buffer_wr_ctrl_pkg;
    localparam int ADDR_LEN = 6;
    localparam int DATA_LEN = 32;
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
endpackage

// File: rtl/buffer_wr_ctrl_if.sv
// buffer_wr_ctrl_if: valid/ready word stream from the memory interface into the write controller.
//   valid  source has a word
//   ready  controller can take a word this cycle
//   data   word
//   last   final word of the frame
//   master: the word source; slave: the write controller
interface buffer_wr_ctrl_if import buffer_wr_ctrl_pkg::*; #(
    parameter int dataLen = DATA_LEN
) ();
    logic               valid;
    logic               ready;
    logic [dataLen-1:0] data;
    logic               last;
    modport master (output valid, data, last, input ready);
    modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/buffer_wr_ctrl_occupancy_counter.sv
// occupancy_counter: tracks buffer occupancy from writes and read-side releases, with clamping.
//   clk, reset    clock, asynchronous active-low reset
//   accept        a word was accepted this cycle
//   rel_en        read side frees rel_num entries this cycle
//   rel_num       number of entries freed
//   count         occupied entries
//   full, empty   count == memSize / count == 0
//   rel_err       sticky: a release exceeded the occupancy
module occupancy_counter #(
    parameter int addrLen = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             accept,
    input  logic             rel_en,
    input  logic [addrLen:0] rel_num,
    output logic [addrLen:0] count,
    output logic             full,
    output logic             empty,
    output logic             rel_err
);
    localparam logic [addrLen:0] MEM_SIZE = {1'b1, {addrLen{1'b0}}};
    // One extra bit so the sum and the underflow test cannot wrap.
    logic [addrLen+1:0] sum, rel, diff;
    logic               over;
    assign sum  = {1'b0, count} + {{(addrLen+1){1'b0}}, accept};
    assign rel  = rel_en ? {1'b0, rel_num} : '0;
    assign over = rel > sum;
    assign diff = sum - rel;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            rel_err <= 1'b0;
        end else begin
            count   <= over ? '0 : diff[addrLen:0];
            rel_err <= rel_err | over;
        end
    end
    assign full  = count == MEM_SIZE;
    assign empty = count == '0;
endmodule

// File: rtl/buffer_wr_ctrl.sv
// buffer_wr_ctrl: turns an accepted word stream into registered single-port buffer writes.
//   clk, reset        clock, asynchronous active-low reset
//   start, base_addr  begin a frame (IDLE only) writing from base_addr
//   src               input word stream (slave side)
//   rel_en, rel_num   read side frees rel_num entries
//   wrt, wrt_addr, data_out  registered write port, one cycle after accept
//   count, full, empty       occupancy
//   frame_done        pulse the cycle after the last write
//   rel_err           sticky over-release flag
// BUFWR_ADDR_WRAP_EN: defined -> pointer wraps (circular); undefined -> pointer saturates at
// memSize-1 and the stream is stalled once that address has been written.
module buffer_wr_ctrl import buffer_wr_ctrl_pkg::*; #(
    parameter int addrLen = ADDR_LEN,
    parameter int dataLen = DATA_LEN
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addrLen-1:0] base_addr,
    buffer_wr_ctrl_if.slave    src,
    input  logic               rel_en,
    input  logic [addrLen:0]   rel_num,
    output logic               wrt,
    output logic [addrLen-1:0] wrt_addr,
    output logic [dataLen-1:0] data_out,
    output logic [addrLen:0]   count,
    output logic               full,
    output logic               empty,
    output logic               frame_done,
    output logic               rel_err
);
    localparam logic [addrLen-1:0] ADDR_MAX = '1;
    state_t             state, state_next;
    logic [addrLen-1:0] ptr, ptr_next;
    logic               stop, at_end, accept, load;
    assign accept = src.valid && src.ready;
    assign load   = start && state == IDLE;
`ifdef BUFWR_ADDR_WRAP_EN
    assign ptr_next = ptr + 1'b1;
    assign at_end   = 1'b0;
`else
    assign ptr_next = ptr == ADDR_MAX ? ptr : ptr + 1'b1;
    assign at_end   = ptr == ADDR_MAX;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end
    always_comb begin
        state_next = state == IDLE ? (start ? FILL : IDLE) :
                     state == FILL ? ((accept && src.last) ? DONE : FILL) : IDLE;
    end
    // Ready depends on registered state only, never on valid.
    always_comb begin
        src.ready = state == FILL && !full && !stop;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr        <= '0;
            stop       <= 1'b0;
            wrt        <= 1'b0;
            wrt_addr   <= '0;
            data_out   <= '0;
            frame_done <= 1'b0;
        end else begin
            ptr        <= load ? base_addr : accept ? ptr_next : ptr;
            stop       <= load ? 1'b0 : (accept && at_end) ? 1'b1 : stop;
            wrt        <= accept;
            wrt_addr   <= accept ? ptr : wrt_addr;
            data_out   <= accept ? src.data : data_out;
            frame_done <= state == DONE;
        end
    end
    occupancy_counter #(.addrLen(addrLen)) u_occ (
        .clk     (clk),
        .reset   (reset),
        .accept  (accept),
        .rel_en  (rel_en),
        .rel_num (rel_num),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .rel_err (rel_err)
    );
endmodule

// File: tb/tb_buffer_wr_ctrl.sv
// tb_buffer_wr_ctrl: directed checks of buffer_wr_ctrl at addrLen 6 (b_*) and addrLen 2 (s_*).
module tb_buffer_wr_ctrl;
`ifdef BUFWR_ADDR_WRAP_EN
    localparam logic WRAP = 1'b1;
`else
    localparam logic WRAP = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic        b_start = 1'b0, b_rel_en = 1'b0, b_wrt, b_full, b_empty, b_done, b_err;
    logic [5:0]  b_base = '0, b_addr;
    logic [6:0]  b_rel_num = '0, b_count;
    logic [31:0] b_dout;
    buffer_wr_ctrl_if #(.dataLen(32)) b_if ();

    logic        s_start = 1'b0, s_rel_en = 1'b0, s_wrt, s_full, s_empty, s_done, s_err;
    logic [1:0]  s_base = '0, s_addr;
    logic [2:0]  s_rel_num = '0, s_count;
    logic [31:0] s_dout;
    buffer_wr_ctrl_if #(.dataLen(32)) s_if ();

    buffer_wr_ctrl u_big (
        .clk(clk), .reset(reset), .start(b_start), .base_addr(b_base), .src(b_if),
        .rel_en(b_rel_en), .rel_num(b_rel_num), .wrt(b_wrt), .wrt_addr(b_addr),
        .data_out(b_dout), .count(b_count), .full(b_full), .empty(b_empty),
        .frame_done(b_done), .rel_err(b_err)
    );
    buffer_wr_ctrl #(.addrLen(2), .dataLen(32)) u_dut (
        .clk(clk), .reset(reset), .start(s_start), .base_addr(s_base), .src(s_if),
        .rel_en(s_rel_en), .rel_num(s_rel_num), .wrt(s_wrt), .wrt_addr(s_addr),
        .data_out(s_dout), .count(s_count), .full(s_full), .empty(s_empty),
        .frame_done(s_done), .rel_err(s_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic s_begin(input logic [1:0] base);
        s_start = 1'b1;
        s_base  = base;
        step();
        s_start = 1'b0;
    endtask

    task automatic s_release(input logic [2:0] n);
        s_rel_en  = 1'b1;
        s_rel_num = n;
        step();
        s_rel_en  = 1'b0;
    endtask

    task automatic s_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        b_if.valid = 1'b0; b_if.data = '0; b_if.last = 1'b0;
        s_if.valid = 1'b0; s_if.data = '0; s_if.last = 1'b0;
        step();
        step();
        @(negedge clk);
        check("rst_wrt", b_wrt, 0);
        check("rst_addr", b_addr, 0);
        check("rst_count", b_count, 0);
        check("rst_empty", b_empty, 1);
        check("rst_full", b_full, 0);
        check("rst_ready", b_if.ready, 0);
        check("rst_done", b_done, 0);
        check("rst_err", b_err, 0);
        step();
        reset = 1'b1;

        // single frame on the wide instance: base 5, words A B C
        b_start = 1'b1; b_base = 6'd5;
        step();
        b_start = 1'b0; b_if.valid = 1'b1; b_if.data = 32'hA;
        @(negedge clk);
        check("sf_ready", b_if.ready, 1);
        step();
        b_if.data = 32'hB;
        @(negedge clk);
        check("sf_wrt0", b_wrt, 1);
        check("sf_addr0", b_addr, 5);
        check("sf_data0", b_dout, 32'hA);
        step();
        b_if.data = 32'hC; b_if.last = 1'b1;
        @(negedge clk);
        check("sf_wrt1", b_wrt, 1);
        check("sf_addr1", b_addr, 6);
        check("sf_data1", b_dout, 32'hB);
        step();
        b_if.valid = 1'b0; b_if.last = 1'b0;
        @(negedge clk);
        check("sf_wrt2", b_wrt, 1);
        check("sf_addr2", b_addr, 7);
        check("sf_data2", b_dout, 32'hC);
        check("sf_count", b_count, 3);
        check("sf_done_early", b_done, 0);
        step();
        @(negedge clk);
        check("sf_wrt_end", b_wrt, 0);
        check("sf_done", b_done, 1);
        step();
        @(negedge clk);
        check("sf_done_pulse", b_done, 0);

        // fill to full on the narrow instance (memSize 4), fifth word waits for a release
        s_begin(2'd0);
        s_if.valid = 1'b1;
        s_if.data  = 32'h10;
        for (int i = 0; i < 4; i++) begin
            step();
            s_if.data = 32'h11 + i;
        end
        @(negedge clk);
        check("ff_full", s_full, 1);
        check("ff_count", s_count, 4);
        check("ff_ready", s_if.ready, 0);
        check("ff_addr3", s_addr, 3);
        check("ff_data3", s_dout, 32'h13);
        step();
        @(negedge clk);
        check("ff_stall_wrt", s_wrt, 0);
        check("ff_stall_count", s_count, 4);
        s_if.last = 1'b1;
        s_release(3'd1);
        @(negedge clk);
        check("ff_rel_count", s_count, 3);
        check("ff_rel_full", s_full, 0);
        check("ff_rel_ready", s_if.ready, WRAP);
        step();
        s_if.valid = 1'b0; s_if.last = 1'b0;
        @(negedge clk);
        check("ff_fifth_wrt", s_wrt, WRAP);
        check("ff_fifth_addr", s_addr, WRAP ? 0 : 3);
        check("ff_fifth_count", s_count, WRAP ? 4 : 3);
        s_reset();

        // write and release in the same cycle, then over-release
        s_begin(2'd0);
        s_if.valid = 1'b1; s_if.data = 32'h20;
        step();
        s_if.data = 32'h21;
        step();
        s_if.data = 32'h22; s_rel_en = 1'b1; s_rel_num = 3'd1;
        @(negedge clk);
        check("sim_count_pre", s_count, 2);
        step();
        s_if.valid = 1'b0; s_rel_en = 1'b0;
        @(negedge clk);
        check("sim_count", s_count, 2);
        check("sim_addr", s_addr, 2);
        check("sim_data", s_dout, 32'h22);
        s_release(3'd1);
        @(negedge clk);
        check("or_count_pre", s_count, 1);
        check("or_err_pre", s_err, 0);
        s_release(3'd3);
        @(negedge clk);
        check("or_count", s_count, 0);
        check("or_empty", s_empty, 1);
        check("or_err", s_err, 1);
        s_if.valid = 1'b1; s_if.data = 32'h23; s_if.last = 1'b1;
        step();
        s_if.valid = 1'b0; s_if.last = 1'b0;
        @(negedge clk);
        check("or_last_addr", s_addr, 3);
        check("or_last_count", s_count, 1);
        step();
        @(negedge clk);
        check("or_done", s_done, 1);
        check("or_err_hold", s_err, 1);

        // wrap boundary: base 3, two words
        s_begin(2'd3);
        s_if.valid = 1'b1; s_if.data = 32'h30;
        step();
        s_if.data = 32'h31; s_if.last = 1'b1;
        @(negedge clk);
        check("wr_addr0", s_addr, 3);
        check("wr_data0", s_dout, 32'h30);
        check("wr_ready", s_if.ready, WRAP);
        step();
        s_if.valid = 1'b0; s_if.last = 1'b0;
        @(negedge clk);
        check("wr_wrt1", s_wrt, WRAP);
        check("wr_addr1", s_addr, WRAP ? 0 : 3);
        check("wr_count", s_count, WRAP ? 3 : 2);
        check("wr_err_hold", s_err, 1);
        step();
        @(negedge clk);
        check("wr_ready_end", s_if.ready, 0);
        s_reset();

        // asynchronous reset in the middle of a frame
        s_begin(2'd1);
        s_if.valid = 1'b1; s_if.data = 32'h40;
        step();
        s_if.data = 32'h41;
        step();
        s_if.data = 32'h42;
        check("mr_wrt_before", s_wrt, 1);
        #2 reset = 1'b0;
        #1;
        check("mr_wrt", s_wrt, 0);
        check("mr_addr", s_addr, 0);
        check("mr_data", s_dout, 0);
        check("mr_count", s_count, 0);
        check("mr_empty", s_empty, 1);
        check("mr_ready", s_if.ready, 0);
        check("mr_err", s_err, 0);
        step();
        check("mr_wrt_held", s_wrt, 0);
        check("mr_done_held", s_done, 0);
        s_if.valid = 1'b0;
        reset = 1'b1;
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
